// File: rtl/axi_addr_queue_splitter.sv
// ============================================================================
// Module   : axi_addr_queue_splitter
// Purpose  : AXI address-channel (AW or AR) request queue. Holds DEPTH
//            {id, addr, len, size, burst} requests behind a valid/ready port.
//            When SPLIT_EN=1, it breaks INCR bursts longer than MAX_BEATS
//            into consecutive fragments of at most MAX_BEATS beats.
//            m_split_last marks the final fragment of each original request,
//            so response logic downstream can merge the split responses.
// Ports    : clk, rstnn (async active-low), clear (sync flush), enable
//            s_a*      : upstream request channel (valid/ready)
//            m_a*      : downstream fragment channel (valid/ready)
//            m_split_last : fragment is the final one of its request
//            occupancy / empty / full : registered FIFO status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

module axi_addr_queue_splitter #(
  parameter int BW_ADDR   = 32,
  parameter int BW_ID     = 4,
  parameter int DEPTH     = 4,
  parameter int SPLIT_EN  = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rstnn,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      s_avalid,
  output logic                      s_aready,
  input  logic [BW_ID-1:0]          s_aid,
  input  logic [BW_ADDR-1:0]        s_aaddr,
  input  logic [`BW_AXI_ALEN-1:0]   s_alen,
  input  logic [`BW_AXI_ASIZE-1:0]  s_asize,
  input  logic [`BW_AXI_ABURST-1:0] s_aburst,
  output logic                      m_avalid,
  input  logic                      m_aready,
  output logic [BW_ID-1:0]          m_aid,
  output logic [BW_ADDR-1:0]        m_aaddr,
  output logic [`BW_AXI_ALEN-1:0]   m_alen,
  output logic [`BW_AXI_ASIZE-1:0]  m_asize,
  output logic [`BW_AXI_ABURST-1:0] m_aburst,
  output logic                      m_split_last,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                      empty,
  output logic                      full
);

  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_occ_w  = $clog2(DEPTH+1);
  localparam int c_alen_w = `BW_AXI_ALEN;
  localparam logic [8:0]                  c_max_beats = 9'(MAX_BEATS);
  localparam logic [c_alen_w-1:0]         c_len_max   = c_alen_w'(MAX_BEATS - 1);
  localparam logic [c_occ_w-1:0]          c_depth     = c_occ_w'(DEPTH);
  localparam logic [`BW_AXI_ABURST-1:0]   c_incr      = `BW_AXI_ABURST'(1);
  localparam logic                        c_split_en  = (SPLIT_EN != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Request storage
  logic [BW_ID-1:0]          r_mem_id    [DEPTH];
  logic [BW_ADDR-1:0]        r_mem_addr  [DEPTH];
  logic [`BW_AXI_ALEN-1:0]   r_mem_len   [DEPTH];
  logic [`BW_AXI_ASIZE-1:0]  r_mem_size  [DEPTH];
  logic [`BW_AXI_ABURST-1:0] r_mem_burst [DEPTH];

  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_occ_w-1:0] r_occ, w_occ_nxt;
  logic               r_empty, r_full;

  state_t             r_state, w_state_nxt;
  logic [8:0]         r_rem, w_rem_nxt;
  logic [BW_ADDR-1:0] r_cur_addr, w_cur_addr_nxt;

  logic [BW_ID-1:0]          w_head_id;
  logic [BW_ADDR-1:0]        w_head_addr;
  logic [`BW_AXI_ALEN-1:0]   w_head_len;
  logic [`BW_AXI_ASIZE-1:0]  w_head_size;
  logic [`BW_AXI_ABURST-1:0] w_head_burst;

  logic [8:0]          w_rem;
  logic [BW_ADDR-1:0]  w_addr;
  logic [BW_ADDR-1:0]  w_addr_step;
  logic [c_alen_w-1:0] w_len_frag;
  logic                w_split;
  logic                w_push, w_fire, w_pop;

  assign w_head_id    = r_mem_id[r_rd_ptr];
  assign w_head_addr  = r_mem_addr[r_rd_ptr];
  assign w_head_len   = r_mem_len[r_rd_ptr];
  assign w_head_size  = r_mem_size[r_rd_ptr];
  assign w_head_burst = r_mem_burst[r_rd_ptr];

  // In IDLE the head is seen fresh; in SPLIT the remaining beat count and
  // running address come from the splitter registers.
  assign w_rem       = (r_state == ST_IDLE) ? ({1'b0, w_head_len} + 9'd1) : r_rem;
  assign w_addr      = (r_state == ST_IDLE) ? w_head_addr : r_cur_addr;
  assign w_addr_step = BW_ADDR'(MAX_BEATS) << w_head_size;
  assign w_len_frag  = c_alen_w'(w_rem - 9'd1);
  assign w_split     = c_split_en && (w_head_burst == c_incr) && (w_rem > c_max_beats);

  // rstnn gates ready so the port reads not-ready while reset is held.
  assign s_aready = rstnn & enable & ~clear & ~r_full;
  assign m_avalid = enable & ~clear & ~r_empty;

  assign w_push = s_avalid & s_aready;
  assign w_fire = m_avalid & m_aready;
  assign w_pop  = w_fire & ~w_split;

  // Data outputs are forced to zero whenever the queue is empty so that
  // reset (which empties the queue asynchronously) zeroes them at once.
  assign m_aid        = r_empty ? '0 : w_head_id;
  assign m_aaddr      = r_empty ? '0 : w_addr;
  assign m_alen       = r_empty ? '0 : (w_split ? c_len_max : w_len_frag);
  assign m_asize      = r_empty ? '0 : w_head_size;
  assign m_aburst     = r_empty ? '0 : w_head_burst;
  assign m_split_last = ~r_empty & ~w_split;

  assign occupancy = r_occ;
  assign empty     = r_empty;
  assign full      = r_full;

  // Splitter next-state
  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_rem;
    w_cur_addr_nxt = r_cur_addr;
    if (w_fire) begin
      if (w_split) begin
        w_state_nxt    = ST_SPLIT;
        w_rem_nxt      = w_rem - c_max_beats;
        w_cur_addr_nxt = w_addr + w_addr_step;
      end else begin
        w_state_nxt    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_cur_addr <= '0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_cur_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_cur_addr <= w_cur_addr_nxt;
    end
  end

  // FIFO bookkeeping
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + c_occ_w'(1);
      2'b01:   w_occ_nxt = r_occ - c_occ_w'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_occ   <= w_occ_nxt;
      r_empty <= (w_occ_nxt == '0);
      r_full  <= (w_occ_nxt == c_depth);
    end
  end

  // Storage needs no reset: contents are only observed when not empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]    <= s_aid;
      r_mem_addr[r_wr_ptr]  <= s_aaddr;
      r_mem_len[r_wr_ptr]   <= s_alen;
      r_mem_size[r_wr_ptr]  <= s_asize;
      r_mem_burst[r_wr_ptr] <= s_aburst;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_addr_queue_splitter.sv
// ============================================================================
// Module   : tb_axi_addr_queue_splitter
// Purpose  : Self-checking bench for axi_addr_queue_splitter (default
//            parameters: DEPTH=4, SPLIT_EN=1, MAX_BEATS=16). A table of
//            per-cycle vectors covers pass-through, splitting, non-INCR
//            bursts, fill/drain and pointer wrap; hand-written sequences
//            cover clear mid-split, enable=0 freeze and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_addr_queue_splitter;

  logic        clk = 1'b0;
  logic        rstnn, clear, enable;
  logic        s_avalid, s_aready;
  logic [3:0]  s_aid;
  logic [31:0] s_aaddr;
  logic [7:0]  s_alen;
  logic [2:0]  s_asize;
  logic [1:0]  s_aburst;
  logic        m_avalid, m_aready;
  logic [3:0]  m_aid;
  logic [31:0] m_aaddr;
  logic [7:0]  m_alen;
  logic [2:0]  m_asize;
  logic [1:0]  m_aburst;
  logic        m_split_last;
  logic [2:0]  occupancy;
  logic        empty, full;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_addr_queue_splitter #(
    .BW_ADDR(32), .BW_ID(4), .DEPTH(4), .SPLIT_EN(1), .MAX_BEATS(16)
  ) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_aid(s_aid),
    .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize), .s_aburst(s_aburst),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_aid(m_aid),
    .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize), .m_aburst(m_aburst),
    .m_split_last(m_split_last), .occupancy(occupancy),
    .empty(empty), .full(full)
  );

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef struct {
    logic        avalid;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        aready;
    logic        e_valid;
    logic        e_ready;
    logic [3:0]  e_id;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic        e_last;
    logic [2:0]  e_occ;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t v(input logic av, input logic [3:0] id, input logic [31:0] ad,
                             input logic [7:0] ln, input logic [2:0] sz, input logic [1:0] bu,
                             input logic ar, input logic ev, input logic er, input logic [3:0] eid,
                             input logic [31:0] ead, input logic [7:0] eln, input logic el,
                             input logic [2:0] eo);
    vec_t r;
    r.avalid = av; r.id = id; r.addr = ad; r.len = ln; r.size = sz; r.burst = bu;
    r.aready = ar; r.e_valid = ev; r.e_ready = er; r.e_id = eid; r.e_addr = ead;
    r.e_len = eln; r.e_last = el; r.e_occ = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic av, input logic [3:0] id, input logic [31:0] ad,
                           input logic [7:0] ln, input logic [2:0] sz, input logic [1:0] bu);
    s_avalid = av; s_aid = id; s_aaddr = ad; s_alen = ln; s_asize = sz; s_aburst = bu;
  endtask

  initial begin
    // Expected behaviour per cycle, observed before the following rising edge.
    //            req: av id  addr      len sz burst  ar | exp: vld rdy id addr     len last occ
    vecs[0]  = v(1, 3,  32'h1000, 3,  2, INCR,  0,  0, 1, 0,  32'h0,    0,  0, 0);
    vecs[1]  = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 3,  32'h1000, 3,  1, 1);
    vecs[2]  = v(1, 5,  32'h2000, 39, 2, INCR,  1,  0, 1, 0,  32'h0,    0,  0, 0);
    vecs[3]  = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 5,  32'h2000, 15, 0, 1);
    vecs[4]  = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 5,  32'h2040, 15, 0, 1);
    vecs[5]  = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 5,  32'h2080, 7,  1, 1);
    vecs[6]  = v(1, 1,  32'h3000, 31, 2, WRAP,  0,  0, 1, 0,  32'h0,    0,  0, 0);
    vecs[7]  = v(1, 2,  32'h4000, 31, 2, FIXED, 1,  1, 1, 1,  32'h3000, 31, 1, 1);
    vecs[8]  = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 2,  32'h4000, 31, 1, 1);
    vecs[9]  = v(0, 0,  32'h0,    0,  0, FIXED, 0,  0, 1, 0,  32'h0,    0,  0, 0);
    vecs[10] = v(1, 8,  32'h5000, 0,  0, INCR,  0,  0, 1, 0,  32'h0,    0,  0, 0);
    vecs[11] = v(1, 9,  32'h5100, 0,  0, INCR,  0,  1, 1, 8,  32'h5000, 0,  1, 1);
    vecs[12] = v(1, 10, 32'h5200, 0,  0, INCR,  0,  1, 1, 8,  32'h5000, 0,  1, 2);
    vecs[13] = v(1, 11, 32'h5300, 0,  0, INCR,  0,  1, 1, 8,  32'h5000, 0,  1, 3);
    vecs[14] = v(1, 12, 32'h5400, 0,  0, INCR,  0,  1, 0, 8,  32'h5000, 0,  1, 4);
    vecs[15] = v(1, 12, 32'h5400, 0,  0, INCR,  1,  1, 0, 8,  32'h5000, 0,  1, 4);
    vecs[16] = v(1, 12, 32'h5400, 0,  0, INCR,  0,  1, 1, 9,  32'h5100, 0,  1, 3);
    vecs[17] = v(1, 13, 32'h5500, 0,  0, INCR,  1,  1, 0, 9,  32'h5100, 0,  1, 4);
    vecs[18] = v(1, 13, 32'h5500, 0,  0, INCR,  1,  1, 1, 10, 32'h5200, 0,  1, 3);
    vecs[19] = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 11, 32'h5300, 0,  1, 3);
    vecs[20] = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 12, 32'h5400, 0,  1, 2);
    vecs[21] = v(0, 0,  32'h0,    0,  0, FIXED, 1,  1, 1, 13, 32'h5500, 0,  1, 1);
    vecs[22] = v(0, 0,  32'h0,    0,  0, FIXED, 0,  0, 1, 0,  32'h0,    0,  0, 0);

    rstnn = 1'b0; clear = 1'b0; enable = 1'b1; m_aready = 1'b0;
    drive_req(0, 0, 0, 0, 0, FIXED);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_aready", s_aready, 0);
    chk("rst_m_avalid", m_avalid, 0);
    chk("rst_m_aaddr",  m_aaddr, 0);
    chk("rst_occ",      occupancy, 0);
    chk("rst_empty",    empty, 1);
    chk("rst_full",     full, 0);
    @(negedge clk);
    rstnn = 1'b1;
    #1;
    chk("post_rst_s_aready", s_aready, 1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_req(vecs[i].avalid, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
      m_aready = vecs[i].aready;
      #1;
      chk($sformatf("v%0d_m_avalid", i), m_avalid, vecs[i].e_valid);
      chk($sformatf("v%0d_s_aready", i), s_aready, vecs[i].e_ready);
      chk($sformatf("v%0d_m_aid", i), m_aid, vecs[i].e_id);
      chk($sformatf("v%0d_m_aaddr", i), m_aaddr, vecs[i].e_addr);
      chk($sformatf("v%0d_m_alen", i), m_alen, vecs[i].e_len);
      chk($sformatf("v%0d_m_split_last", i), m_split_last, vecs[i].e_last);
      chk($sformatf("v%0d_occupancy", i), occupancy, vecs[i].e_occ);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].e_occ == 3'd0);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_occ == 3'd4);
    end

    // Clear asserted after the first fragment of a 40-beat request
    @(negedge clk);
    drive_req(1, 6, 32'h6000, 39, 2, INCR);
    m_aready = 1'b1;
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0, FIXED);
    #1;
    chk("clr_frag0_addr",  m_aaddr, 32'h6000);
    chk("clr_frag0_len",   m_alen, 15);
    chk("clr_frag0_last",  m_split_last, 0);
    chk("clr_frag0_size",  m_asize, 2);
    chk("clr_frag0_burst", m_aburst, INCR);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clr_m_avalid", m_avalid, 0);
    chk("clr_s_aready", s_aready, 0);
    @(negedge clk);
    clear = 1'b0;
    m_aready = 1'b0;
    drive_req(1, 7, 32'h7000, 3, 2, INCR);
    #1;
    chk("clr_after_occ",    occupancy, 0);
    chk("clr_after_empty",  empty, 1);
    chk("clr_after_avalid", m_avalid, 0);
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0, FIXED);
    #1;
    chk("clr_new_avalid", m_avalid, 1);
    chk("clr_new_id",     m_aid, 7);
    chk("clr_new_addr",   m_aaddr, 32'h7000);
    chk("clr_new_len",    m_alen, 3);
    chk("clr_new_last",   m_split_last, 1);
    chk("clr_new_occ",    occupancy, 1);

    // enable=0 freezes everything even with both sides requesting
    @(negedge clk);
    enable = 1'b0;
    m_aready = 1'b1;
    drive_req(1, 9, 32'h9000, 39, 2, INCR);
    #1;
    chk("en0_s_aready", s_aready, 0);
    chk("en0_m_avalid", m_avalid, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("en0_occ", occupancy, 1);
    @(negedge clk);
    enable = 1'b1;
    m_aready = 1'b0;
    drive_req(0, 0, 0, 0, 0, FIXED);
    #1;
    chk("en1_m_avalid", m_avalid, 1);
    chk("en1_m_aid",    m_aid, 7);
    chk("en1_m_aaddr",  m_aaddr, 32'h7000);
    chk("en1_m_alen",   m_alen, 3);

    // Asynchronous reset pulse between clock edges
    @(negedge clk);
    #2;
    rstnn = 1'b0;
    #1;
    chk("arst_m_avalid", m_avalid, 0);
    chk("arst_m_aaddr",  m_aaddr, 0);
    chk("arst_m_alen",   m_alen, 0);
    chk("arst_m_aid",    m_aid, 0);
    chk("arst_occ",      occupancy, 0);
    chk("arst_empty",    empty, 1);
    chk("arst_s_aready", s_aready, 0);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_after_avalid", m_avalid, 0);
    chk("arst_after_occ",    occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_addr_queue_splitter.md
Name: axi_addr_queue_splitter

Overview:
- Parametrised AXI address-channel (AW or AR) queue.
- Buffers DEPTH requests of {id, addr, len, size, burst} behind a valid/ready slave port.
- Optionally splits long INCR bursts into sub-bursts of at most MAX_BEATS beats.
- Sits between an interconnect master port and a slave that limits burst length; the per-fragment last flag lets downstream response logic merge split responses.

Parameters:
- BW_ADDR, 32, address width.
- BW_ID, 4, AXI ID width.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- SPLIT_EN, 1, 1 enables INCR splitting; 0 passes every request unchanged.
- MAX_BEATS, 16, maximum beats per output fragment; power of 2, 1..256.

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush
- enable  in  1  global handshake enable
- s_avalid  in  1  request valid
- s_aready  out  1  request ready
- s_aid  in  BW_ID  request ID
- s_aaddr  in  BW_ADDR  request address
- s_alen  in  `BW_AXI_ALEN  request beats-1
- s_asize  in  `BW_AXI_ASIZE  request beat size
- s_aburst  in  `BW_AXI_ABURST  request burst type
- m_avalid  out  1  fragment valid
- m_aready  in  1  fragment ready
- m_aid  out  BW_ID  fragment ID
- m_aaddr  out  BW_ADDR  fragment address
- m_alen  out  `BW_AXI_ALEN  fragment beats-1
- m_asize  out  `BW_AXI_ASIZE  fragment beat size
- m_aburst  out  `BW_AXI_ABURST  fragment burst type
- m_split_last  out  1  fragment is the final one of its original request
- occupancy  out  clog2(DEPTH+1)  stored entries
- empty  out  1  occupancy==0
- full  out  1  occupancy==DEPTH

Behaviour:
- Reset (rstnn=0, asynchronous): pointers=0, occupancy=0, splitter IDLE, all m_* outputs 0, s_aready=0, empty=1, full=0.
- s_aready = enable & !clear & !full. Push occurs when s_avalid & s_aready.
- No bypass: an entry pushed at cycle N can appear on m_* at cycle N+1 at the earliest.
- m_avalid = enable & !clear & !empty. m_* outputs come from the head entry and splitter state; they are stable while m_avalid & !m_aready.
- enable=0: no push, no pop, all state frozen.
- clear=1: pointers, occupancy and splitter return to reset values at the next edge. clear has priority over enable and over any concurrent handshake; such handshakes are not performed.
- Splitter states:
  - IDLE: no split in progress. The head is presented with rem=s_alen+1 and cur_addr=head addr.
  - SPLIT: a fragment of the head has already been issued.
- Split needed when SPLIT_EN=1, burst==INCR (2'b01) and rem>MAX_BEATS.
- Split needed:
  - m_alen=MAX_BEATS-1, m_split_last=0.
  - On handshake: rem-=MAX_BEATS; cur_addr+=(MAX_BEATS<<size), modulo 2^BW_ADDR; state=SPLIT; no pop.
- Split not needed:
  - m_alen=rem-1, m_split_last=1.
  - On handshake: pop the head; state=IDLE.
- FIXED, WRAP, reserved burst types, and SPLIT_EN=0: always single fragment with original len and m_split_last=1.
- ID, size and burst are copied unchanged to every fragment.
- rem is 9 bits wide (max 256).
- No 4KB-boundary check is performed; the upstream master guarantees AXI legality.
- Simultaneous push and pop: occupancy unchanged. A push while full is impossible because s_aready=0, even if a pop occurs in the same cycle.
- Pointer wrap-around is modulo DEPTH.
- occupancy, empty and full are registered and consistent with the pointers every cycle.
- Reset asserted mid-split: fragment state is discarded; after reset, nothing is output.

Test Plan:
- Reset, then enable=1 → s_aready=1, m_avalid=0, occupancy=0. Push id=3, addr=0x1000, len=3, INCR → next cycle m_* = {3, 0x1000, 3, INCR}, m_split_last=1. Pop → empty=1.
- SPLIT_EN=1, MAX_BEATS=16, push addr=0x2000, len=39, size=2, INCR, m_aready=1 → fragments (0x2000, len 15, last 0), (0x2040, len 15, last 0), (0x2080, len 7, last 1). Pop occurs only after the third fragment.
- Push WRAP len=31 and FIXED len=31 → each is passed as a single fragment with len=31 and m_split_last=1.
- m_aready=0, push 4 requests → full=1, s_aready=0, occupancy=4. Pop and push in the same cycle with m_aready=1 → occupancy stays 4 after re-fill; FIFO order is preserved across pointer wrap.
- Mid-split (after first fragment of a len=39 request), assert clear for 1 cycle → occupancy=0, m_avalid=0. Next push len=3 emits addr=new, len=3, without stale rem.
- enable=0 with s_avalid=1, m_aready=1 → no handshakes, state unchanged. Async rstnn pulse between clock edges → outputs zero immediately.
